ddr_game_sequencer: RTL and testbench
=====================================

// Module: ddr_game_sequencer
// PURPOSE
//  Game-level controller for the falling-arrow rhythm game. Sequences IDLE -> COUNTDOWN -> PLAY -> OVER.
//  Schedules arrow spawns (lane + timing) into the arrow/graphic datapath over a valid/ready handshake.
//  Derives difficulty (arrow speed, spawn period) from the running score, and tracks lives from miss pulses.
//  Sits between button/LFSR inputs and the arrow datapath; runs in the pixel clock domain.
// PARAMETERS
//  SPAWN_PERIOD_INIT  200  frames between spawns at level 0
//  SPAWN_PERIOD_MIN   60   floor on spawn period
//  SPAWN_STEP         20   period decrement per level
//  SCORE_STEP         10   score points per level-up
//  SPEED_MAX          3    ceiling on arr_speed
//  COUNTDOWN_FRAMES   180  frames spent in COUNTDOWN
//  LIVES_INIT         3    lives loaded at game start (max 7)
// PORTS
//  clk          in   1   pixel clock
//  reset        in   1   async, active-low
//  frame_tick   in   1   1-cycle pulse at pixel (0,0)
//  btn_start    in   1   raw start button, asynchronous
//  rand         in   5   LFSR output; [1:0] selects lane
//  score        in   16  current score from the datapath
//  miss         in   1   1-cycle pulse: an arrow passed the score line
//  spawn_ready  in   1   datapath can accept a spawn this cycle
//  spawn_valid  out  1   spawn request pending
//  spawn_lane   out  2   0=U 1=D 2=R 3=L; stable while spawn_valid
//  clear_req    out  1   1-cycle pulse: datapath clears arrows and score
//  arr_speed    out  6   pixels/frame arrow velocity
//  game_active  out  1   high only in PLAY
//  lives        out  3   remaining lives
//  game_state   out  2   0 IDLE, 1 COUNTDOWN, 2 PLAY, 3 OVER
//  drop_count   out  8   spawns lost to back-pressure, saturating
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE; spawn_valid=0; spawn_lane=0; clear_req=0; arr_speed=1;
//    lives=0; drop_count=0; level=0; period=SPAWN_PERIOD_INIT; threshold=SCORE_STEP.
//  - btn_start passes a 2-FF synchroniser and a rising-edge detector; start_pulse lags the button by 3 clk.
//  - IDLE or OVER, on start_pulse: -> COUNTDOWN. Same cycle: clear_req=1, lives=LIVES_INIT, level=0,
//    arr_speed=1, period=INIT, threshold=SCORE_STEP, drop_count=0, cd_cnt=COUNTDOWN_FRAMES-1.
//    start_pulse is ignored in COUNTDOWN and PLAY.
//  - COUNTDOWN: on frame_tick, cd_cnt decrements. frame_tick while cd_cnt==0 -> PLAY with frame_cnt=0.
//  - PLAY spawn timer: frame_cnt increments on frame_tick. On a frame_tick with frame_cnt>=period-1:
//    frame_cnt=0 and a spawn is due. Due while spawn_valid=0: next cycle spawn_valid=1, spawn_lane=rand[1:0].
//    Due while spawn_valid=1 (not yet accepted): spawn dropped, drop_count+1 (saturates at 255).
//  - Handshake: transfer occurs in a cycle with spawn_valid&&spawn_ready; spawn_valid falls next cycle.
//    spawn_lane must not change while spawn_valid=1.
//  - Difficulty: evaluated every cycle in PLAY. If score>=threshold (17-bit compare) and level<15:
//    level+1, threshold+=SCORE_STEP, arr_speed=min(arr_speed+1,SPEED_MAX), period=max(period-STEP,MIN).
//    At most one level per cycle; a large score jump catches up over successive cycles.
//  - Lives: miss in PLAY decrements lives. miss when lives==1 -> lives=0 and -> OVER. miss outside PLAY is ignored.
//  - Simultaneous miss + spawn-due + level-up in one cycle: all three take effect. If the miss is fatal,
//    OVER wins and no spawn is issued.
//  - Entering OVER, or leaving PLAY for any reason: spawn_valid forced 0, pending spawn discarded without counting.
//    arr_speed holds its value.
//  - Reset mid-game returns everything to reset values immediately; no clear_req is issued.
// STRUCTURE
//  - ddr_pkg: state encoding (ST_IDLE..ST_OVER), lane encoding (LANE_U/D/R/L), shared by datapath and sequencer.
//  - Sub-module ddr_btn_edge: 2-FF synchroniser + rising-edge pulse, reused for the lane buttons.
//  - Single 2-bit state register plus counters (cd_cnt 8b, frame_cnt 8b, period 8b, level 4b, threshold 17b).
// TESTING
//  1. Reset, pulse btn_start -> clear_req one cycle, lives=3, state=1. After 180 frame_ticks -> state=2, game_active=1.
//  2. PLAY, spawn_ready=1, rand=5'b00010 -> spawn_valid at the 200th frame_tick, lane=2, one-cycle accept.
//  3. spawn_ready=0 for 450 frames -> one spawn held with lane stable; drop_count=1 after the second due spawn.
//  4. score stepped 0->10->20->30 -> arr_speed 2,3,3; period 180,160,140; score forced 0->50 -> level 5 within 5 cycles.
//  5. Three miss pulses -> lives 2,1,0 and state=3; pending spawn cleared. Simultaneous fatal miss+spawn -> no spawn.
//  6. Assert reset mid-PLAY with spawn_valid=1 -> all outputs at reset values the same cycle (async).

Source files
------------

// File: rtl/ddr_pkg.sv
// Shared encodings and default tuning constants for the rhythm-game sequencer
// and the arrow datapath.
package ddr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_COUNTDOWN = 2'd1,
      ST_PLAY      = 2'd2,
      ST_OVER      = 2'd3
   } game_state_e;

   typedef enum logic [1:0] {
      LANE_U = 2'd0,
      LANE_D = 2'd1,
      LANE_R = 2'd2,
      LANE_L = 2'd3
   } lane_e;

   localparam logic [7:0]  SPAWN_PERIOD_INIT_DEF = 8'd200;
   localparam logic [7:0]  SPAWN_PERIOD_MIN_DEF  = 8'd60;
   localparam logic [7:0]  SPAWN_STEP_DEF        = 8'd20;
   localparam logic [16:0] SCORE_STEP_DEF        = 17'd10;
   localparam logic [5:0]  SPEED_MAX_DEF         = 6'd3;
   localparam logic [7:0]  COUNTDOWN_FRAMES_DEF  = 8'd180;
   localparam logic [2:0]  LIVES_INIT_DEF        = 3'd3;
   localparam logic [3:0]  LEVEL_MAX             = 4'd15;

   // Saturating 8-bit increment used by the drop counter.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/ddr_btn_edge.sv
// Two-flop synchroniser followed by a rising-edge detector. The pulse is
// one clock wide and is consumed by the caller on the third clock edge
// after the button rises.
module ddr_btn_edge (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic pulse_o
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   // Synchronise the raw button and keep one delayed copy for edge detection.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/ddr_game_sequencer.sv
// Game-level sequencer for the falling-arrow rhythm game: countdown, spawn
// scheduling over valid/ready, score-driven difficulty and life tracking.
//
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   ST_IDLE      | after reset, waiting for start
//   ST_COUNTDOWN | COUNTDOWN_FRAMES frame ticks before play begins
//   ST_PLAY      | spawns issued, difficulty raised, misses cost lives
//   ST_OVER      | lives exhausted, waiting for start to replay
module ddr_game_sequencer
   import ddr_pkg::*;
#(
   parameter logic [7:0]  SPAWN_PERIOD_INIT = SPAWN_PERIOD_INIT_DEF,
   parameter logic [7:0]  SPAWN_PERIOD_MIN  = SPAWN_PERIOD_MIN_DEF,
   parameter logic [7:0]  SPAWN_STEP        = SPAWN_STEP_DEF,
   parameter logic [16:0] SCORE_STEP        = SCORE_STEP_DEF,
   parameter logic [5:0]  SPEED_MAX         = SPEED_MAX_DEF,
   parameter logic [7:0]  COUNTDOWN_FRAMES  = COUNTDOWN_FRAMES_DEF,
   parameter logic [2:0]  LIVES_INIT        = LIVES_INIT_DEF
) (
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic        frame_tick_i,
   input  logic        btn_start_i,
   input  logic [4:0]  rand_i,
   input  logic [15:0] score_i,
   input  logic        miss_i,
   input  logic        spawn_ready_i,
   output logic        spawn_valid_o,
   output logic [1:0]  spawn_lane_o,
   output logic        clear_req_o,
   output logic [5:0]  arr_speed_o,
   output logic        game_active_o,
   output logic [2:0]  lives_o,
   output logic [1:0]  game_state_o,
   output logic [7:0]  drop_count_o
);

   game_state_e state_q, state_d;
   logic [7:0]  cd_cnt_q, cd_cnt_d;
   logic [7:0]  frame_cnt_q, frame_cnt_d;
   logic [7:0]  period_q, period_d;
   logic [3:0]  level_q, level_d;
   logic [16:0] threshold_q, threshold_d;
   logic [5:0]  speed_q, speed_d;
   logic [2:0]  lives_q, lives_d;
   logic        spawn_valid_q, spawn_valid_d;
   logic [1:0]  spawn_lane_q, spawn_lane_d;
   logic        clear_req_q, clear_req_d;
   logic [7:0]  drop_cnt_q, drop_cnt_d;

   logic start_pulse;
   logic spawn_due;
   logic fatal_miss;
   logic unused_rand;

   // Only the low two random bits pick the lane.
   assign unused_rand = ^rand_i[4:2];

   ddr_btn_edge u_start_edge (
      .clk_i   (clk_i),
      .rst_ni  (reset_ni),
      .btn_i   (btn_start_i),
      .pulse_o (start_pulse)
   );

   // State and counter registers.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q       <= ST_IDLE;
         cd_cnt_q      <= '0;
         frame_cnt_q   <= '0;
         period_q      <= SPAWN_PERIOD_INIT;
         level_q       <= '0;
         threshold_q   <= SCORE_STEP;
         speed_q       <= 6'd1;
         lives_q       <= '0;
         spawn_valid_q <= 1'b0;
         spawn_lane_q  <= '0;
         clear_req_q   <= 1'b0;
         drop_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         cd_cnt_q      <= cd_cnt_d;
         frame_cnt_q   <= frame_cnt_d;
         period_q      <= period_d;
         level_q       <= level_d;
         threshold_q   <= threshold_d;
         speed_q       <= speed_d;
         lives_q       <= lives_d;
         spawn_valid_q <= spawn_valid_d;
         spawn_lane_q  <= spawn_lane_d;
         clear_req_q   <= clear_req_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

   // Next-state logic: game flow, spawn timer, difficulty and lives.
   always_comb begin
      state_d       = state_q;
      cd_cnt_d      = cd_cnt_q;
      frame_cnt_d   = frame_cnt_q;
      period_d      = period_q;
      level_d       = level_q;
      threshold_d   = threshold_q;
      speed_d       = speed_q;
      lives_d       = lives_q;
      spawn_valid_d = spawn_valid_q;
      spawn_lane_d  = spawn_lane_q;
      clear_req_d   = 1'b0;
      drop_cnt_d    = drop_cnt_q;
      spawn_due     = 1'b0;
      fatal_miss    = 1'b0;

      case (state_q)
         ST_IDLE, ST_OVER: begin
            if (start_pulse) begin
               state_d     = ST_COUNTDOWN;
               clear_req_d = 1'b1;
               lives_d     = LIVES_INIT;
               level_d     = '0;
               speed_d     = 6'd1;
               period_d    = SPAWN_PERIOD_INIT;
               threshold_d = SCORE_STEP;
               drop_cnt_d  = '0;
               cd_cnt_d    = COUNTDOWN_FRAMES - 8'd1;
            end
         end

         ST_COUNTDOWN: begin
            if (frame_tick_i) begin
               if (cd_cnt_q == 8'd0) begin
                  state_d     = ST_PLAY;
                  frame_cnt_d = '0;
               end else begin
                  cd_cnt_d = cd_cnt_q - 8'd1;
               end
            end
         end

         ST_PLAY: begin
            fatal_miss = miss_i && (lives_q <= 3'd1);

            if (spawn_valid_q && spawn_ready_i) begin
               spawn_valid_d = 1'b0;
            end

            if (frame_tick_i) begin
               if (frame_cnt_q >= period_q - 8'd1) begin
                  frame_cnt_d = '0;
                  spawn_due   = 1'b1;
               end else begin
                  frame_cnt_d = frame_cnt_q + 8'd1;
               end
            end

            // A spawn accepted this very cycle frees the slot for the new one.
            if (spawn_due && !fatal_miss) begin
               if (!spawn_valid_q || spawn_ready_i) begin
                  spawn_valid_d = 1'b1;
                  spawn_lane_d  = rand_i[1:0];
               end else begin
                  drop_cnt_d = sat_inc8(drop_cnt_q);
               end
            end

            if (({1'b0, score_i} >= threshold_q) && (level_q != LEVEL_MAX)) begin
               level_d     = level_q + 4'd1;
               threshold_d = threshold_q + SCORE_STEP;
               speed_d     = (speed_q < SPEED_MAX) ? speed_q + 6'd1 : SPEED_MAX;
               period_d    = (period_q >= SPAWN_PERIOD_MIN + SPAWN_STEP) ?
                             period_q - SPAWN_STEP : SPAWN_PERIOD_MIN;
            end

            if (miss_i) begin
               if (fatal_miss) begin
                  lives_d       = '0;
                  state_d       = ST_OVER;
                  spawn_valid_d = 1'b0;
               end else begin
                  lives_d = lives_q - 3'd1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign spawn_valid_o = spawn_valid_q;
   assign spawn_lane_o  = spawn_lane_q;
   assign clear_req_o   = clear_req_q;
   assign arr_speed_o   = speed_q;
   assign game_active_o = (state_q == ST_PLAY);
   assign lives_o       = lives_q;
   assign game_state_o  = state_q;
   assign drop_count_o  = drop_cnt_q;

endmodule

// File: tb/tb_ddr_game_sequencer.sv
// Directed bench for the rhythm-game sequencer: three games covering start,
// countdown, spawn handshake, back-pressure drops, difficulty, lives and
// asynchronous reset.
module tb_ddr_game_sequencer;

   logic        clk;
   logic        reset_n;
   logic        frame_tick;
   logic        btn_start;
   logic [4:0]  rand_v;
   logic [15:0] score;
   logic        miss;
   logic        spawn_ready;
   logic        spawn_valid;
   logic [1:0]  spawn_lane;
   logic        clear_req;
   logic [5:0]  arr_speed;
   logic        game_active;
   logic [2:0]  lives;
   logic [1:0]  game_state;
   logic [7:0]  drop_count;

   int checks = 0;
   int errors = 0;

   ddr_game_sequencer dut (
      .clk_i         (clk),
      .reset_ni      (reset_n),
      .frame_tick_i  (frame_tick),
      .btn_start_i   (btn_start),
      .rand_i        (rand_v),
      .score_i       (score),
      .miss_i        (miss),
      .spawn_ready_i (spawn_ready),
      .spawn_valid_o (spawn_valid),
      .spawn_lane_o  (spawn_lane),
      .clear_req_o   (clear_req),
      .arr_speed_o   (arr_speed),
      .game_active_o (game_active),
      .lives_o       (lives),
      .game_state_o  (game_state),
      .drop_count_o  (drop_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "time limit");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ftick(input int n);
      repeat (n) begin
         frame_tick = 1'b1;
         cyc(1);
         frame_tick = 1'b0;
         cyc(1);
      end
   endtask

   task automatic miss_pulse();
      miss = 1'b1;
      cyc(1);
      miss = 1'b0;
   endtask

   initial begin
      reset_n     = 1'b0;
      frame_tick  = 1'b0;
      btn_start   = 1'b0;
      rand_v      = 5'd0;
      score       = 16'd0;
      miss        = 1'b0;
      spawn_ready = 1'b0;
      #23;
      chk("rst_state", 32'(game_state), 0);
      chk("rst_valid", 32'(spawn_valid), 0);
      chk("rst_lane", 32'(spawn_lane), 0);
      chk("rst_clear", 32'(clear_req), 0);
      chk("rst_speed", 32'(arr_speed), 1);
      chk("rst_lives", 32'(lives), 0);
      chk("rst_drop", 32'(drop_count), 0);
      chk("rst_active", 32'(game_active), 0);
      reset_n = 1'b1;
      cyc(2);

      // Game 1: start, countdown
      btn_start = 1'b1;
      cyc(2);
      chk("start_lag2_state", 32'(game_state), 0);
      cyc(1);
      chk("start_state", 32'(game_state), 1);
      chk("start_clear", 32'(clear_req), 1);
      chk("start_lives", 32'(lives), 3);
      cyc(1);
      chk("clear_one_cycle", 32'(clear_req), 0);
      btn_start = 1'b0;
      ftick(179);
      chk("cd_179_state", 32'(game_state), 1);
      chk("cd_179_active", 32'(game_active), 0);
      ftick(1);
      chk("cd_180_state", 32'(game_state), 2);
      chk("cd_180_active", 32'(game_active), 1);

      // First spawn at the 200th frame tick, accepted in one cycle
      rand_v      = 5'b00010;
      spawn_ready = 1'b1;
      ftick(199);
      chk("spawn1_early", 32'(spawn_valid), 0);
      frame_tick = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
      chk("spawn1_valid", 32'(spawn_valid), 1);
      chk("spawn1_lane", 32'(spawn_lane), 2);
      cyc(1);
      chk("spawn1_accepted", 32'(spawn_valid), 0);

      // Back-pressure: held spawn, lane stable, one drop
      spawn_ready = 1'b0;
      rand_v      = 5'd1;
      ftick(199);
      chk("bp_early", 32'(spawn_valid), 0);
      ftick(1);
      chk("bp_valid", 32'(spawn_valid), 1);
      chk("bp_lane", 32'(spawn_lane), 1);
      rand_v = 5'd3;
      ftick(199);
      chk("bp_no_drop_yet", 32'(drop_count), 0);
      ftick(1);
      chk("bp_drop", 32'(drop_count), 1);
      chk("bp_held_valid", 32'(spawn_valid), 1);
      ftick(50);
      chk("bp_lane_stable", 32'(spawn_lane), 1);
      spawn_ready = 1'b1;
      cyc(1);
      chk("bp_released", 32'(spawn_valid), 0);
      spawn_ready = 1'b0;

      // Difficulty stepping (frame_cnt is now 50)
      score = 16'd10;
      cyc(1);
      chk("lvl1_speed", 32'(arr_speed), 2);
      score = 16'd20;
      cyc(1);
      chk("lvl2_speed", 32'(arr_speed), 3);
      score = 16'd30;
      cyc(1);
      chk("lvl3_speed_cap", 32'(arr_speed), 3);
      ftick(89);
      chk("period140_early", 32'(spawn_valid), 0);
      ftick(1);
      chk("period140_due", 32'(spawn_valid), 1);
      score = 16'd0;
      cyc(1);
      score = 16'd50;
      cyc(4);
      chk("lvl5_speed", 32'(arr_speed), 3);
      spawn_ready = 1'b1;
      cyc(1);
      chk("lvl5_accept", 32'(spawn_valid), 0);
      spawn_ready = 1'b0;
      ftick(99);
      chk("period100_early", 32'(spawn_valid), 0);
      ftick(1);
      chk("period100_due", 32'(spawn_valid), 1);

      // Lives
      miss_pulse();
      chk("miss1_lives", 32'(lives), 2);
      chk("miss1_valid_kept", 32'(spawn_valid), 1);
      miss_pulse();
      chk("miss2_lives", 32'(lives), 1);
      miss_pulse();
      chk("miss3_lives", 32'(lives), 0);
      chk("miss3_state", 32'(game_state), 3);
      chk("miss3_valid", 32'(spawn_valid), 0);
      chk("miss3_active", 32'(game_active), 0);
      chk("over_speed_hold", 32'(arr_speed), 3);
      miss_pulse();
      chk("over_miss_ignored", 32'(lives), 0);

      // Game 2: restart from OVER, start ignored in COUNTDOWN, fast level-up
      score     = 16'd0;
      btn_start = 1'b1;
      cyc(3);
      chk("g2_state", 32'(game_state), 1);
      chk("g2_clear", 32'(clear_req), 1);
      chk("g2_lives", 32'(lives), 3);
      chk("g2_speed", 32'(arr_speed), 1);
      chk("g2_drop", 32'(drop_count), 0);
      btn_start = 1'b0;
      cyc(3);
      btn_start = 1'b1;
      cyc(3);
      chk("g2_cd_start_ignored", 32'(clear_req), 0);
      btn_start = 1'b0;
      ftick(180);
      chk("g2_play", 32'(game_state), 2);
      score = 16'd50;
      cyc(1);
      chk("g2_jump_step1", 32'(arr_speed), 2);
      cyc(1);
      chk("g2_jump_step2", 32'(arr_speed), 3);
      cyc(3);
      miss_pulse();
      miss_pulse();
      chk("g2_lives1", 32'(lives), 1);
      rand_v = 5'd2;
      ftick(99);
      chk("g2_period100_early", 32'(spawn_valid), 0);
      frame_tick = 1'b1;
      miss       = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
      miss       = 1'b0;
      chk("g2_fatal_state", 32'(game_state), 3);
      chk("g2_fatal_no_spawn", 32'(spawn_valid), 0);
      chk("g2_fatal_lives", 32'(lives), 0);
      chk("g2_fatal_no_drop", 32'(drop_count), 0);
      cyc(2);
      chk("g2_still_no_spawn", 32'(spawn_valid), 0);

      // Game 3: async reset mid-PLAY with a pending spawn
      score     = 16'd0;
      btn_start = 1'b1;
      cyc(3);
      chk("g3_state", 32'(game_state), 1);
      btn_start = 1'b0;
      ftick(180);
      rand_v = 5'd3;
      ftick(200);
      chk("g3_pending", 32'(spawn_valid), 1);
      chk("g3_lane", 32'(spawn_lane), 3);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_state", 32'(game_state), 0);
      chk("arst_valid", 32'(spawn_valid), 0);
      chk("arst_lane", 32'(spawn_lane), 0);
      chk("arst_lives", 32'(lives), 0);
      chk("arst_speed", 32'(arr_speed), 1);
      chk("arst_active", 32'(game_active), 0);
      #2;
      reset_n = 1'b1;
      cyc(2);
      chk("arst_no_clear", 32'(clear_req), 0);
      chk("arst_idle", 32'(game_state), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
